// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// Package : io_pkg
// Purpose : Shared definitions for the memory-mapped board I/O controller:
//           register word offsets, DISP_CTRL reset value and the hex to
//           7-segment glyph function (active-high segments {g..a}).
// Rev     : 1.0  initial release
// ============================================================================
package io_pkg;

   localparam logic [1:0]  c_addr_disp_data = 2'd0;
   localparam logic [1:0]  c_addr_disp_ctrl = 2'd1;
   localparam logic [1:0]  c_addr_sw        = 2'd2;
   localparam logic [1:0]  c_addr_btn       = 2'd3;

   // {display enable, dp mask, digit enable mask}
   localparam logic [16:0] c_disp_ctrl_rst  = 17'h1_00FF;

   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         default: seg = 7'h71;
      endcase
      return seg;
   endfunction

endpackage
`default_nettype wire

// File: rtl/io_debounce.sv
`default_nettype none
// ============================================================================
// Module  : io_debounce
// Purpose : Synchronises one raw asynchronous button and debounces it.
//           level only changes after the synchronised input has disagreed
//           with it for DEB_CYCLES consecutive cycles; rise pulses for one
//           cycle, coincident with the 0->1 change of level.
// Ports   : clk, reset_n (async, active-low), raw (async button),
//           level (debounced), rise (1-cycle press pulse)
// Rev     : 1.0  initial release
// ============================================================================
module io_debounce #(
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int            c_cw   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [c_cw-1:0] c_last = c_cw'(DEB_CYCLES - 1);
   localparam logic [c_cw-1:0] c_one  = c_cw'(1);

   logic            r_sync1;
   logic            r_sync2;
   logic            r_level;
   logic [c_cw-1:0] r_cnt;
   logic            w_flip;

   // The cycle the disagreement count reaches its limit is the toggle cycle.
   assign w_flip = (r_sync2 != r_level) && (r_cnt == c_last);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= raw;
         r_sync2 <= r_sync1;
         // Any agreement (bounce back) restarts the count from zero.
         if ((r_sync2 == r_level) || w_flip)
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + c_one;
         if (w_flip)
            r_level <= ~r_level;
      end
   end

   assign level = r_level;
   assign rise  = w_flip & ~r_level;

endmodule
`default_nettype wire

// File: rtl/mmio_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mmio_io_ctrl
// Purpose : Memory-mapped board I/O controller beside data memory. Scans an
//           8-digit 7-segment display, debounces BTNL/BTNR with latched
//           press flags (W1C) and synchronises the slide switches.
// Ports   : clk, reset_n (async, active-low)
//           io_sel/io_we/io_addr[1:0]/io_wdata[31:0] - bus write side
//           io_rdata[31:0] - combinational read data (not gated by io_sel)
//           btn_l, btn_r, sw[15:0] - raw asynchronous board inputs
//           an[7:0], dp, a2g[6:0] - registered active-low display drives
// Rev     : 1.0  initial release
// ============================================================================
module mmio_io_ctrl
   import io_pkg::*;
#(
   parameter int SCAN_DIV   = 100_000,
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        io_sel,
   input  logic        io_we,
   input  logic [1:0]  io_addr,
   input  logic [31:0] io_wdata,
   output logic [31:0] io_rdata,
   input  logic        btn_l,
   input  logic        btn_r,
   input  logic [15:0] sw,
   output logic [7:0]  an,
   output logic        dp,
   output logic [6:0]  a2g
);

   localparam int              c_pw       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [c_pw-1:0] c_pre_last = c_pw'(SCAN_DIV - 1);
   localparam logic [c_pw-1:0] c_pre_one  = c_pw'(1);

   logic [31:0]     r_disp_data;
   logic [16:0]     r_disp_ctrl;
   logic [15:0]     r_sw_meta;
   logic [15:0]     r_sw_sync;
   logic [1:0]      r_flag;
   logic [c_pw-1:0] r_pre;
   logic [2:0]      r_idx;
   logic [7:0]      r_an;
   logic [6:0]      r_a2g;
   logic            r_dp;

   logic            w_wr;
   logic [1:0]      w_raw;
   logic [1:0]      w_level;
   logic [1:0]      w_rise;
   logic [7:0]      w_msk;
   logic [7:0]      w_dpm;
   logic            w_lit;
   logic [3:0]      w_nib;

   assign w_wr  = io_sel & io_we;
   assign w_raw = {btn_r, btn_l};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_btn
         io_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (w_raw[gi]),
            .level   (w_level[gi]),
            .rise    (w_rise[gi])
         );
      end
   endgenerate

   // Registers, switch synchroniser and press flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_disp_data <= '0;
         r_disp_ctrl <= c_disp_ctrl_rst;
         r_sw_meta   <= '0;
         r_sw_sync   <= '0;
         r_flag      <= '0;
      end else begin
         r_sw_meta <= sw;
         r_sw_sync <= r_sw_meta;
         if (w_wr && io_addr == c_addr_disp_data)
            r_disp_data <= io_wdata;
         if (w_wr && io_addr == c_addr_disp_ctrl)
            r_disp_ctrl <= io_wdata[16:0];
         // A new press outranks a simultaneous W1C so no event is lost.
         for (int i = 0; i < 2; i++) begin
            if (w_rise[i])
               r_flag[i] <= 1'b1;
            else if (w_wr && io_addr == c_addr_btn && io_wdata[8+i])
               r_flag[i] <= 1'b0;
         end
      end
   end

   // Digit scan prescaler and index
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pre <= '0;
         r_idx <= '0;
      end else if (r_pre == c_pre_last) begin
         r_pre <= '0;
         r_idx <= r_idx + 3'd1;
      end else begin
         r_pre <= r_pre + c_pre_one;
      end
   end

   assign w_msk = r_disp_ctrl[7:0];
   assign w_dpm = r_disp_ctrl[15:8];
   assign w_lit = r_disp_ctrl[16] & w_msk[r_idx];
   assign w_nib = r_disp_data[{r_idx, 2'b00} +: 4];

   // Display drives are re-registered every cycle, so they follow an index
   // step or a DISP_* write one cycle later.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_an  <= 8'hFF;
         r_a2g <= 7'h7F;
         r_dp  <= 1'b1;
      end else if (w_lit) begin
         r_an  <= ~(8'b1 << r_idx);
         r_a2g <= ~hex7(w_nib);
         r_dp  <= ~w_dpm[r_idx];
      end else begin
         r_an  <= 8'hFF;
         r_a2g <= 7'h7F;
         r_dp  <= 1'b1;
      end
   end

   assign an  = r_an;
   assign a2g = r_a2g;
   assign dp  = r_dp;

   always_comb begin
      io_rdata = '0;
      case (io_addr)
         c_addr_disp_data: io_rdata = r_disp_data;
         c_addr_disp_ctrl: io_rdata = {15'b0, r_disp_ctrl};
         c_addr_sw:        io_rdata = {16'b0, r_sw_sync};
         default:          io_rdata = {22'b0, r_flag, 6'b0, w_level};
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_mmio_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mmio_io_ctrl
// Purpose : Scoreboard bench for mmio_io_ctrl with a cycle-level reference
//           model (SCAN_DIV=4, DEB_CYCLES=8): directed scenarios followed by
//           random bus/button/switch traffic.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mmio_io_ctrl;

   localparam int SD = 4;
   localparam int DB = 8;
   localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        io_sel = 1'b0;
   logic        io_we = 1'b0;
   logic [1:0]  io_addr = 2'd0;
   logic [31:0] io_wdata = 32'd0;
   logic [31:0] io_rdata;
   logic        btn_l = 1'b0;
   logic        btn_r = 1'b0;
   logic [15:0] sw = 16'd0;
   logic [7:0]  an;
   logic        dp;
   logic [6:0]  a2g;

   always #5 clk = ~clk;

   mmio_io_ctrl #(.SCAN_DIV(SD), .DEB_CYCLES(DB)) dut (
      .clk(clk), .reset_n(reset_n), .io_sel(io_sel), .io_we(io_we), .io_addr(io_addr),
      .io_wdata(io_wdata), .io_rdata(io_rdata), .btn_l(btn_l), .btn_r(btn_r), .sw(sw),
      .an(an), .dp(dp), .a2g(a2g)
   );

   int compared = 0;
   int mismatched = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {logic [7:0] an; logic [6:0] a2g; logic dp;} disp_t;
   typedef struct packed {logic [1:0] addr; logic [31:0] data;} rd_t;
   disp_t dq[$];
   rd_t   rq[$];

   int          m_cyc;
   logic [31:0] m_data;
   logic [7:0]  m_msk, m_dpm;
   logic        m_en;
   logic [15:0] m_sw1, m_swsync;
   logic [1:0]  m_r1, m_r2, m_lvl, m_flag;
   int          m_run [2];

   task automatic model_reset();
      m_cyc = 0; m_data = '0; m_msk = 8'hFF; m_dpm = '0; m_en = 1'b1;
      m_sw1 = '0; m_swsync = '0; m_r1 = '0; m_r2 = '0; m_lvl = '0; m_flag = '0;
      m_run[0] = 0; m_run[1] = 0;
      dq.delete(); rq.delete();
   endtask

   function automatic logic [31:0] mread(input logic [1:0] a);
      case (a)
         2'd0:    return m_data;
         2'd1:    return {15'b0, m_en, m_dpm, m_msk};
         2'd2:    return {16'b0, m_swsync};
         default: return {22'b0, m_flag, 6'b0, m_lvl};
      endcase
   endfunction

   // One clock edge: record what the display must show afterwards, then
   // advance buttons, switches and registers.
   task automatic model_step();
      int    idx;
      logic  lit, wr, rise;
      logic [1:0] s;
      disp_t e;
      idx = (m_cyc / SD) % 8;
      lit = m_en & m_msk[idx];
      e.an  = lit ? ~(8'd1 << idx) : 8'hFF;
      e.a2g = lit ? ~GLYPH[m_data[idx*4 +: 4]] : 7'h7F;
      e.dp  = lit ? ~m_dpm[idx] : 1'b1;
      dq.push_back(e);
      wr = io_sel & io_we;
      s = m_r2; m_r2 = m_r1; m_r1 = {btn_r, btn_l};
      for (int i = 0; i < 2; i++) begin
         rise = 1'b0;
         if (s[i] != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == DB) begin
               m_lvl[i] = s[i]; m_run[i] = 0; rise = s[i];
            end
         end else begin
            m_run[i] = 0;
         end
         if (wr && io_addr == 2'd3 && io_wdata[8+i]) m_flag[i] = 1'b0;
         if (rise) m_flag[i] = 1'b1;
      end
      m_swsync = m_sw1; m_sw1 = sw;
      if (wr && io_addr == 2'd0) m_data = io_wdata;
      if (wr && io_addr == 2'd1) {m_en, m_dpm, m_msk} = io_wdata[16:0];
      m_cyc++;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) model_reset();
         else model_step();
      end
   end

   // ---------------- monitor ----------------
   initial begin
      disp_t e;
      rd_t   r;
      forever begin
         @(negedge clk);
         #2;
         if (dq.size() > 0) begin
            e = dq.pop_front();
            check("disp{an,a2g,dp}", {16'b0, an, a2g, dp}, {16'b0, e});
         end
         if (rq.size() > 0) begin
            r = rq.pop_front();
            check($sformatf("rdata[addr%0d]", r.addr), io_rdata, r.data);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic bus(input logic sel, input logic we, input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      io_sel = sel; io_we = we; io_addr = a; io_wdata = d;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus(1'b1, 1'b1, a, d);
   endtask

   task automatic rd(input logic [1:0] a);
      rd_t r;
      bus(1'b1, 1'b0, a, $urandom);
      r.addr = a; r.data = mread(a);
      rq.push_back(r);
   endtask

   task automatic idle(input int n);
      repeat (n) bus(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("reset an/a2g/dp", {16'b0, an, a2g, dp}, {16'b0, 8'hFF, 7'h7F, 1'b1});
      io_addr = 2'd1; #1 check("reset DISP_CTRL", io_rdata, 32'h0001_00FF);
      io_addr = 2'd0; #1 check("reset DISP_DATA", io_rdata, 32'h0);
      io_addr = 2'd3; #1 check("reset BTN", io_rdata, 32'h0);
      io_addr = 2'd2; #1 check("reset SW", io_rdata, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // Scan sequence with all digits lit
      wr(2'd0, 32'h7654_3210);
      idle(70);
      // Partial enable with dp mask, then everything off
      wr(2'd1, 32'h0001_0F05);
      idle(40);
      wr(2'd1, 32'h0);
      idle(40);
      wr(2'd1, 32'h0001_00FF);

      // Clean btn_l press, then bouncing around the held level
      idle(1); btn_l = 1'b1;
      idle(14); rd(2'd3);
      repeat (4) begin
         idle(1); btn_l = 1'b0; idle(2);
         idle(1); btn_l = 1'b1; idle(2);
      end
      rd(2'd3);

      // W1C of btn_l flag on the very edge where btn_r's level rises
      idle(1); btn_r = 1'b1;
      idle(8);
      wr(2'd3, 32'h0000_0100);
      rd(2'd3);
      idle(3); rd(2'd3);

      // Switch synchroniser; SW register ignores writes
      idle(1); sw = 16'hA5C3;
      idle(3); rd(2'd2);
      wr(2'd2, 32'hFFFF_FFFF);
      rd(2'd2);

      // Random traffic
      repeat (400) begin
         case ($urandom_range(0, 9))
            0: wr(2'd0, $urandom);
            1: wr(2'd1, $urandom);
            2: wr(2'd3, $urandom);
            3: wr(2'd2, $urandom);
            4: bus(1'b0, 1'b1, 2'($urandom_range(0, 3)), $urandom);
            5, 6, 7: rd(2'($urandom_range(0, 3)));
            default: idle(1);
         endcase
         if ($urandom_range(0, 15) == 0) btn_l = ~btn_l;
         if ($urandom_range(0, 15) == 0) btn_r = ~btn_r;
         if ($urandom_range(0, 20) == 0) sw = 16'($urandom);
      end

      // Reset in the middle of a scan and a debounce
      wr(2'd1, 32'h0001_00FF);
      btn_l = 1'b1; btn_r = 1'b1;
      idle(20);
      btn_l = 1'b0;
      idle(3); btn_l = 1'b1;
      idle(4);
      #3 reset_n = 1'b0;
      #1;
      check("async reset an/a2g/dp", {16'b0, an, a2g, dp}, {16'b0, 8'hFF, 7'h7F, 1'b1});
      io_addr = 2'd3; #1 check("async reset BTN", io_rdata, 32'h0);
      io_addr = 2'd1; #1 check("async reset DISP_CTRL", io_rdata, 32'h0001_00FF);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      rd(2'd3);
      idle(12); rd(2'd3);
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
